synchronizer: RTL and testbench
===============================

// Module: synchronizer
// PURPOSE
// - Control glue between the router FSM, the input-side register block and the three output FIFOs.
// - Latches the 2-bit destination address at header detect.
// - Steers the single write strobe to the addressed FIFO and returns that FIFO's full flag.
// - Generates per-port valid-out from FIFO empty flags.
// - Issues a per-FIFO soft reset when a destination leaves valid data unread for TIMEOUT clocks.
// PARAMETERS
// - TIMEOUT  30  consecutive unread-valid clocks before soft_reset pulses
// - CNT_W    5   width of each timeout counter (must hold TIMEOUT-1)
// PORTS
// - clock          in   1  single system clock, all state on rising edge
// - resetn         in   1  asynchronous, active-HIGH reset (1 = reset, despite name)
// - detect_add     in   1  header-byte strobe from FSM; latch din as address
// - write_enb_reg  in   1  FSM request to write current byte into addressed FIFO
// - full           in   3  full flags, FIFO2..FIFO0
// - empty          in   3  empty flags, FIFO2..FIFO0
// - read_enb       in   3  per-destination read enables, FIFO2..FIFO0
// - din            in   2  destination address (low 2 bits of header)
// - vld_out        out  3  valid-out to each destination
// - soft_reset     out  3  one-clock soft-reset pulse per FIFO (registered)
// - write_enb      out  3  one-hot write enable to FIFOs
// - fifo_full      out  1  full flag of currently addressed FIFO
// BEHAVIOUR
// - Reset (resetn=1, async):
//   - addr_q=2'b00; all counters=0; soft_reset=3'b000.
//   - write_enb=3'b000 and fifo_full=0, forced while reset asserted.
//   - vld_out still follows ~empty.
// - Address latch: at posedge, if detect_add=1 then addr_q<=din, else hold.
//   - New address is visible to write_enb/fifo_full from the next cycle.
// - write_enb (combinational):
//   - write_enb_reg=0 -> 000.
//   - Else decode addr_q: 00->001, 01->010, 10->100, 11->000 (invalid port, no write).
// - fifo_full (combinational): addr_q 00->full[0], 01->full[1], 10->full[2], 11->0.
//   - Independent of write_enb_reg.
// - vld_out[i] = ~empty[i] (combinational, zero latency).
// - Timeout, per port i, independent counter cnt[i]:
//   - If vld_out[i]=1 and read_enb[i]=0:
//     - cnt[i]==TIMEOUT-1 -> soft_reset[i]<=1, cnt[i]<=0.
//     - Else cnt[i]<=cnt[i]+1, soft_reset[i]<=0.
//   - Otherwise cnt[i]<=0, soft_reset[i]<=0.
//   - Any read or empty clock restarts the count.
//   - Pulse appears after the 30th consecutive qualifying edge and lasts exactly one clock.
//   - If the condition persists, the pulse repeats every 30 clocks.
// - No wrap: counter never exceeds TIMEOUT-1.
// - Ports are fully independent; simultaneous pulses on several ports are allowed.
// - detect_add and write_enb_reg in the same cycle: write_enb uses the OLD addr_q that cycle.
// - Reset mid-count: counters clear immediately; any pending pulse is dropped.
// TESTING
// - Reset, empty=3'b111, write_enb_reg=1 -> write_enb=000, fifo_full=0, soft_reset=000, vld_out=000.
// - Address decode: detect_add=1, din=2'b10 for one clock, then write_enb_reg=1
//   -> write_enb=100, fifo_full tracks full[2].
//   - Repeat with din=00/01/11 -> 001/010/000; full=3'b001 with addr 00 -> fifo_full=1.
// - empty=3'b100, read_enb=3'b000 -> vld_out=011.
//   - soft_reset[1:0] pulse high for one clock after exactly 30 edges, again at 60.
//   - soft_reset[2] stays 0.
// - empty=3'b100, read_enb=3'b101 -> only soft_reset[1] pulses every 30 clocks; soft_reset[0]=0 throughout.
// - Timeout restart: hold vld_out[0]=1 unread 29 clocks, read_enb[0]=1 one clock, then unread again
//   -> no pulse until 30 further clocks.
// - Assert resetn at count 20 -> counters clear, no pulse.
//   - After release, a full 30 clocks are again required.

Source files
------------

// File: rtl/synchronizer_if.sv
// Router control bus between the FSM/register side, the output FIFOs and the synchronizer.
interface synchronizer_if;
    logic       detect_add;
    logic       write_enb_reg;
    logic [2:0] full;
    logic [2:0] empty;
    logic [2:0] read_enb;
    logic [1:0] din;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic [2:0] write_enb;
    logic       fifo_full;

    modport master (
        output detect_add, write_enb_reg, full, empty, read_enb, din,
        input  vld_out, soft_reset, write_enb, fifo_full
    );

    modport slave (
        input  detect_add, write_enb_reg, full, empty, read_enb, din,
        output vld_out, soft_reset, write_enb, fifo_full
    );
endinterface

// File: rtl/synchronizer.sv
// Router synchronizer: latches destination address, steers writes to the addressed FIFO,
// and soft-resets any FIFO whose valid data sits unread for TIMEOUT clocks.
module synchronizer #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic          clock,
    input  logic          resetn,
    synchronizer_if.slave bus
);

    logic [1:0]       addr_q, addr_d;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];
    logic [2:0]       soft_reset_q, soft_reset_d;
    logic [2:0]       stale;

    assign stale = ~bus.empty & ~bus.read_enb;

    always_comb begin
        addr_d       = bus.detect_add ? bus.din : addr_q;
        soft_reset_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (stale[i]) begin
                // Terminal count emits the pulse and restarts, so it repeats every TIMEOUT clocks.
                if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            addr_q       <= '0;
            soft_reset_q <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            addr_q       <= addr_d;
            soft_reset_q <= soft_reset_d;
            for (int unsigned i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        bus.write_enb = '0;
        bus.fifo_full = 1'b0;
        if (!resetn) begin
            unique case (addr_q)
                2'b00:   bus.fifo_full = bus.full[0];
                2'b01:   bus.fifo_full = bus.full[1];
                2'b10:   bus.fifo_full = bus.full[2];
                default: bus.fifo_full = 1'b0;
            endcase
            if (bus.write_enb_reg) begin
                unique case (addr_q)
                    2'b00:   bus.write_enb = 3'b001;
                    2'b01:   bus.write_enb = 3'b010;
                    2'b10:   bus.write_enb = 3'b100;
                    default: bus.write_enb = 3'b000;
                endcase
            end
        end
    end

    assign bus.vld_out    = ~bus.empty;
    assign bus.soft_reset = soft_reset_q;

endmodule

// File: tb/tb_synchronizer.sv
// Directed self-checking bench for the router synchronizer.
module tb_synchronizer;

    logic clock;
    logic resetn;
    int   n_cmp;
    int   n_err;

    synchronizer_if bus ();

    synchronizer #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp             = 0;
        n_err             = 0;
        resetn            = 1'b1;
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b111;
        bus.empty         = 3'b111;
        bus.read_enb      = 3'b000;
        bus.din           = 2'b00;
        #1;

        // Reset state
        chk("rst_write_enb",  bus.write_enb,          3'b000);
        chk("rst_fifo_full",  {2'b00, bus.fifo_full}, 3'b000);
        chk("rst_soft_reset", bus.soft_reset,         3'b000);
        chk("rst_vld_out",    bus.vld_out,            3'b000);
        bus.empty = 3'b010;
        #1;
        chk("rst_vld_follow", bus.vld_out,            3'b101);
        tick();
        tick();
        bus.empty = 3'b111;
        tick();
        resetn = 1'b0;
        #1;
        chk("post_rst_we",    bus.write_enb,          3'b001);

        // Address decode
        bus.write_enb_reg = 1'b0;
        bus.detect_add    = 1'b1;
        bus.din           = 2'b10;
        tick();
        bus.detect_add    = 1'b0;
        bus.write_enb_reg = 1'b1;
        bus.full          = 3'b100;
        #1;
        chk("dec10_we",   bus.write_enb,          3'b100);
        chk("dec10_ff1",  {2'b00, bus.fifo_full}, 3'b001);
        bus.full = 3'b011;
        #1;
        chk("dec10_ff0",  {2'b00, bus.fifo_full}, 3'b000);

        bus.detect_add = 1'b1;
        bus.din        = 2'b00;
        #1;
        chk("same_cycle_old_addr", bus.write_enb, 3'b100);
        tick();
        bus.detect_add = 1'b0;
        bus.full       = 3'b001;
        #1;
        chk("dec00_we",   bus.write_enb,          3'b001);
        chk("dec00_ff",   {2'b00, bus.fifo_full}, 3'b001);
        bus.write_enb_reg = 1'b0;
        #1;
        chk("dec00_noreq", bus.write_enb,          3'b000);
        chk("ff_indep_req", {2'b00, bus.fifo_full}, 3'b001);
        bus.write_enb_reg = 1'b1;

        bus.detect_add = 1'b1;
        bus.din        = 2'b01;
        tick();
        bus.detect_add = 1'b0;
        bus.full       = 3'b010;
        #1;
        chk("dec01_we",   bus.write_enb,          3'b010);
        chk("dec01_ff",   {2'b00, bus.fifo_full}, 3'b001);

        bus.detect_add = 1'b1;
        bus.din        = 2'b11;
        tick();
        bus.detect_add = 1'b0;
        bus.full       = 3'b111;
        #1;
        chk("dec11_we",   bus.write_enb,          3'b000);
        chk("dec11_ff",   {2'b00, bus.fifo_full}, 3'b000);
        bus.write_enb_reg = 1'b0;

        // Timeout on ports 0 and 1, port 2 empty
        bus.empty    = 3'b100;
        bus.read_enb = 3'b000;
        #1;
        chk("vld_011", bus.vld_out, 3'b011);
        for (int k = 1; k <= 65; k++) begin
            tick();
            chk($sformatf("to01_k%0d", k), bus.soft_reset,
                (k == 30 || k == 60) ? 3'b011 : 3'b000);
        end

        // Port 0 and 2 read, only port 1 times out
        bus.empty = 3'b111;
        tick();
        chk("clear_a", bus.soft_reset, 3'b000);
        bus.empty    = 3'b100;
        bus.read_enb = 3'b101;
        for (int k = 1; k <= 60; k++) begin
            tick();
            chk($sformatf("to1_k%0d", k), bus.soft_reset,
                (k % 30 == 0) ? 3'b010 : 3'b000);
        end

        // Restart on a single read clock
        bus.empty    = 3'b111;
        bus.read_enb = 3'b000;
        tick();
        chk("clear_b", bus.soft_reset, 3'b000);
        bus.empty = 3'b110;
        for (int k = 1; k <= 29; k++) begin
            tick();
            chk($sformatf("pre_read_k%0d", k), bus.soft_reset, 3'b000);
        end
        bus.read_enb = 3'b001;
        tick();
        chk("read_clk", bus.soft_reset, 3'b000);
        bus.read_enb = 3'b000;
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk($sformatf("restart_k%0d", k), bus.soft_reset,
                (k == 30) ? 3'b001 : 3'b000);
        end

        // Reset mid-count
        bus.empty = 3'b111;
        tick();
        chk("clear_c", bus.soft_reset, 3'b000);
        bus.empty = 3'b110;
        for (int k = 1; k <= 20; k++) begin
            tick();
        end
        bus.write_enb_reg = 1'b1;
        resetn = 1'b1;
        #1;
        chk("midrst_sr", bus.soft_reset,          3'b000);
        chk("midrst_we", bus.write_enb,           3'b000);
        chk("midrst_ff", {2'b00, bus.fifo_full},  3'b000);
        tick();
        tick();
        chk("midrst_hold", bus.soft_reset, 3'b000);
        resetn = 1'b0;
        #1;
        chk("midrst_we_after", bus.write_enb,          3'b001);
        chk("midrst_ff_after", {2'b00, bus.fifo_full}, 3'b001);
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk($sformatf("postrst_k%0d", k), bus.soft_reset,
                (k == 30) ? 3'b001 : 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
